ground_scroller: RTL and testbench

GROUND_SCROLLER -- requirements
Module: ground_scroller

---
 rtl/ground_pkg.sv | 23 ++
 rtl/ground_pattern_ram.sv | 37 +++
 rtl/ground_scroller.sv | 147 ++++++++++++++
 tb/tb_ground_scroller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ground_pkg.sv
// Shared types and defaults for the scrolling ground strip: FSM state,
// default geometry constants and the offset-width helper.
package ground_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_TILE_W       = 40;
  localparam int DEF_TILE_CNT     = 4;
  localparam int DEF_STRIP_H      = 8;
  localparam int DEF_STRIP_Y      = 400;
  localparam int DEF_SPEED_W      = 4;
  localparam int DEF_MAX_SPEED    = 8;
  localparam int DEF_ACCEL_FRAMES = 256;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ground_pattern_ram.sv
// Ground pattern storage: STRIP_H rows of PATTERN_W bits, one write port,
// one combinational bit-read port. Resets to a single solid middle row.
module ground_pattern_ram
  import ground_pkg::*;
#(
  parameter  int STRIP_H   = DEF_STRIP_H,
  parameter  int PATTERN_W = DEF_TILE_W * DEF_TILE_CNT,
  localparam int ROW_W     = pos_width(STRIP_H),
  localparam int POS_W     = pos_width(PATTERN_W)
) (
  input  logic                 clk,
  input  logic                 N_rst,
  input  logic                 wr_en,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic [PATTERN_W-1:0] wr_data,
  input  logic [ROW_W-1:0]     rd_row,
  input  logic [POS_W-1:0]     rd_col,
  output logic                 rd_bit
);

  logic [PATTERN_W-1:0] mem_q [STRIP_H];

  // NOTE: this array is plain flops, not a RAM macro, so it can and must be
  // reset to give a visible ground line before any pattern is loaded.
  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      for (int r = 0; r < STRIP_H; r++) begin
        mem_q[r] <= (r == STRIP_H / 2) ? {PATTERN_W{1'b1}} : {PATTERN_W{1'b0}};
      end
    end else if (wr_en && (int'(wr_row) < STRIP_H)) begin
      mem_q[wr_row] <= wr_data;
    end
  end

  assign rd_bit = mem_q[rd_row][rd_col];

endmodule

// File: rtl/ground_scroller.sv
// Horizontally scrolling ground strip for a VGA scene. Define GROUND_ACCEL_EN
// to let the scroll speed ramp up every ACCEL_FRAMES frames while running.
module ground_scroller
  import ground_pkg::*;
#(
  parameter  int TILE_W       = DEF_TILE_W,
  parameter  int TILE_CNT     = DEF_TILE_CNT,
  parameter  int STRIP_H      = DEF_STRIP_H,
  parameter  int STRIP_Y      = DEF_STRIP_Y,
  parameter  int SPEED_W      = DEF_SPEED_W,
  parameter  int MAX_SPEED    = DEF_MAX_SPEED,
  parameter  int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  localparam int PATTERN_W    = TILE_W * TILE_CNT,
  localparam int POS_W        = pos_width(PATTERN_W),
  localparam int ROW_W        = pos_width(STRIP_H)
) (
  input  logic                 clk,
  input  logic                 N_rst,
  input  logic [8:0]           row_addr,
  input  logic [9:0]           col_addr,
  input  logic                 game_status,
  input  logic                 fresh,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [ROW_W-1:0]     pat_row,
  input  logic [PATTERN_W-1:0] pat_data,
  output logic [POS_W-1:0]     ground_position,
  output logic [SPEED_W-1:0]   speed,
  output logic                 px
);

  // Wide enough for the largest column plus the largest offset.
  localparam int COL_W = (pos_width(1024 + PATTERN_W) > 11) ? pos_width(1024 + PATTERN_W) : 11;

  state_e             state_q, state_d;
  logic               fresh_q;
  logic               frame_tick;
  logic               running;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [POS_W:0]     pos_sum;
  logic               px_q, px_d;
  logic               in_strip;
  logic [COL_W-1:0]   col_sum;
  logic [POS_W-1:0]   col_idx;
  logic [ROW_W-1:0]   rd_row;
  logic               rd_bit;
  logic [SPEED_W-1:0] speed_w;

  assign frame_tick = fresh_q & ~fresh;
  // A falling game_status takes effect this cycle, not one cycle later.
  assign running    = (state_q == ST_RUN) && game_status;

  ground_pattern_ram #(
    .STRIP_H   (STRIP_H),
    .PATTERN_W (PATTERN_W)
  ) u_ram (
    .clk     (clk),
    .N_rst   (N_rst),
    .wr_en   (pat_valid && pat_ready),
    .wr_row  (pat_row),
    .wr_data (pat_data),
    .rd_row  (rd_row),
    .rd_col  (col_idx),
    .rd_bit  (rd_bit)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = game_status ? ST_RUN : ST_IDLE;
    pos_sum  = {1'b0, pos_q} + (POS_W+1)'(speed_w);
    if (pos_sum >= (POS_W+1)'(PATTERN_W)) begin
      pos_sum = pos_sum - (POS_W+1)'(PATTERN_W);
    end
    pos_d    = pos_q;
    if (running && frame_tick) begin
      pos_d = POS_W'(pos_sum);
    end
    in_strip = ({1'b0, row_addr} >= 10'(STRIP_Y)) &&
               ({1'b0, row_addr} <  10'(STRIP_Y + STRIP_H));
    rd_row   = ROW_W'(row_addr - 9'(STRIP_Y));
    col_sum  = COL_W'(col_addr) + COL_W'(pos_q);
    col_idx  = POS_W'(col_sum % COL_W'(PATTERN_W));
    px_d     = running && in_strip && rd_bit;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      state_q <= ST_IDLE;
      fresh_q <= 1'b0;
      pos_q   <= '0;
      px_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= fresh;
      pos_q   <= pos_d;
      px_q    <= px_d;
    end
  end

`ifdef GROUND_ACCEL_EN
  localparam int CNT_W = pos_width(ACCEL_FRAMES);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  always_comb begin
    cnt_d   = cnt_q;
    speed_d = speed_q;
    if (!running) begin
      cnt_d   = '0;
      speed_d = SPEED_W'(1);
    end else if (frame_tick) begin
      if (cnt_q == CNT_W'(ACCEL_FRAMES - 1)) begin
        cnt_d = '0;
        if (speed_q < SPEED_W'(MAX_SPEED)) begin
          speed_d = speed_q + SPEED_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      cnt_q   <= '0;
      speed_q <= SPEED_W'(1);
    end else begin
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
    end
  end

  assign speed_w = speed_q;
`else
  assign speed_w = SPEED_W'(1);
`endif

  assign pat_ready       = (state_q == ST_IDLE);
  assign ground_position = pos_q;
  assign speed           = speed_w;
  assign px              = px_q;

endmodule

// File: tb/tb_ground_scroller.sv
// Self-checking bench for ground_scroller: directed scenarios plus a
// randomized phase compared against a behavioural model of the strip.
module tb_ground_scroller;

  localparam int PW   = 160;
  localparam int SH   = 8;
  localparam int SY   = 400;
  localparam int AF   = 4;
  localparam int MAXS = 8;

  logic          clk = 1'b0;
  logic          N_rst;
  logic [8:0]    row_addr;
  logic [9:0]    col_addr;
  logic          game_status;
  logic          fresh;
  logic          pat_valid;
  logic          pat_ready;
  logic [2:0]    pat_row;
  logic [PW-1:0] pat_data;
  logic [7:0]    ground_position;
  logic [3:0]    speed;
  logic          px;

  int n_checks = 0;
  int n_fail   = 0;

  ground_scroller #(
    .ACCEL_FRAMES (AF)
  ) dut (
    .clk             (clk),
    .N_rst           (N_rst),
    .row_addr        (row_addr),
    .col_addr        (col_addr),
    .game_status     (game_status),
    .fresh           (fresh),
    .pat_valid       (pat_valid),
    .pat_ready       (pat_ready),
    .pat_row         (pat_row),
    .pat_data        (pat_data),
    .ground_position (ground_position),
    .speed           (speed),
    .px              (px)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer position/speed, pattern as an array of rows.
  bit [PW-1:0] m_pat [SH];
  int m_pos, m_speed, m_ticks;
  bit m_run, m_prev, m_px;

  always @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      m_pos   <= 0;
      m_speed <= 1;
      m_ticks <= 0;
      m_run   <= 1'b0;
      m_prev  <= 1'b0;
      m_px    <= 1'b0;
      for (int r = 0; r < SH; r++) m_pat[r] <= (r == SH / 2) ? {PW{1'b1}} : {PW{1'b0}};
    end else begin
      m_prev <= fresh;
      m_run  <= game_status;
      if (!m_run && pat_valid) m_pat[pat_row] <= pat_data;
      if (m_run && game_status) begin
        if (m_prev && !fresh) begin
          m_pos <= (m_pos + m_speed) % PW;
`ifdef GROUND_ACCEL_EN
          m_ticks <= m_ticks + 1;
          if ((m_ticks + 1) % AF == 0) m_speed <= (m_speed < MAXS) ? m_speed + 1 : MAXS;
`endif
        end
        if (row_addr >= SY && row_addr < SY + SH)
          m_px <= m_pat[row_addr - SY][(col_addr + m_pos) % PW];
        else
          m_px <= 1'b0;
      end else begin
        m_speed <= 1;
        m_ticks <= 0;
        m_px    <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_px"},    px,              m_px);
    check({tag, "_pos"},   ground_position, m_pos);
    check({tag, "_speed"}, speed,           m_speed);
    check({tag, "_ready"}, pat_ready,       !m_run);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    fresh = 1'b1;
    cyc();
    fresh = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    N_rst = 1'b0; row_addr = '0; col_addr = '0; game_status = 1'b0;
    fresh = 1'b0; pat_valid = 1'b0; pat_row = '0; pat_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos",   ground_position, 0);
    check("rst_speed", speed,           1);
    check("rst_px",    px,              0);
    check("rst_ready", pat_ready,       1);

    // Solid middle row: dark while idle, lit once running.
    N_rst = 1'b1; row_addr = 9'd404; col_addr = '0;
    cyc(); cyc();
    check("idle_px404", px, 0);
    game_status = 1'b1;
    cyc(); cyc();
    check("run_px404", px, 1);
    row_addr = 9'd400; cyc();
    check("run_px400", px, 0);
    row_addr = 9'd407; cyc();
    check("run_px407", px, 0);
    check("run_speed", speed, 1);
    check("run_pos0",  ground_position, 0);

`ifndef GROUND_ACCEL_EN
    repeat (200) tick();
    check("pos_200", ground_position, 40);
    repeat (119) tick();
    check("pos_159", ground_position, 159);
    tick();
    check("pos_wrap", ground_position, 0);
`else
    repeat (200) tick();
    check("pos_200", ground_position, m_pos);
`endif

    // Single-bit pattern, scrolled by 3.
    N_rst = 1'b0; cyc();
    N_rst = 1'b1; game_status = 1'b0;
    pat_valid = 1'b1; pat_row = 3'd0; pat_data = '0; pat_data[5] = 1'b1;
    cyc();
    pat_valid = 1'b0; game_status = 1'b1;
    cyc();
    repeat (3) tick();
    check("pos_3", ground_position, 3);
    row_addr = 9'd400;
    for (int c = 0; c < 8; c++) begin
      col_addr = 10'(c);
      cyc();
      check($sformatf("bit5_col%0d", c), px, (c == 2) ? 1 : 0);
    end
    row_addr = 9'd401; col_addr = 10'd2; cyc();
    check("bit5_row401", px, 0);

    // Write attempt while running must be refused.
    pat_valid = 1'b1; pat_row = 3'd0; pat_data = '0;
    check("run_ready", pat_ready, 0);
    cyc(); cyc();
    pat_valid = 1'b0; row_addr = 9'd400; col_addr = 10'd2;
    cyc();
    check("run_nowrite", px, 1);

    // Stop on the very cycle of a frame tick.
    fresh = 1'b1; cyc();
    fresh = 1'b0; game_status = 1'b0; cyc();
    check("stop_pos",   ground_position, 3);
    check("stop_speed", speed,           1);
    check("stop_ready", pat_ready,       1);
    check("stop_px",    px,              0);

    game_status = 1'b1; cyc();
`ifdef GROUND_ACCEL_EN
    repeat (4) tick();
    check("accel_4", speed, 2);
    repeat (24) tick();
    check("accel_28", speed, 8);
    repeat (8) tick();
    check("accel_sat", speed, 8);
    check("accel_pos", ground_position, m_pos);
`else
    repeat (1000) tick();
    check("const_speed", speed, 1);
    check("const_pos", ground_position, (3 + 1000) % PW);
`endif

    // Asynchronous reset in the middle of a lit strip row.
    row_addr = 9'd404; col_addr = 10'd17;
    cyc(); cyc();
    check("pre_rst_px", px, 1);
    #2 N_rst = 1'b0;
    #1;
    check("arst_px",    px,              0);
    check("arst_pos",   ground_position, 0);
    check("arst_speed", speed,           1);
    #2 N_rst = 1'b1;
    #1;
    check("arst_idle", pat_ready, 1);
    check("arst_px2",  px,        0);
    cyc();

    // Randomized phase against the model.
    game_status = 1'b0;
    cyc();
    for (int i = 0; i < 4000; i++) begin
      check_model("rnd");
      if ($urandom_range(99) < 2) game_status = ~game_status;
      if ($urandom_range(2) == 0) fresh = ~fresh;
      row_addr  = 9'(396 + $urandom_range(15));
      col_addr  = 10'($urandom_range(1023));
      pat_valid = ($urandom_range(7) == 0);
      pat_row   = 3'($urandom_range(7));
      for (int k = 0; k < PW / 32; k++) pat_data[k*32 +: 32] = $urandom;
      if (i == 2000) begin
        N_rst = 1'b0;
        #1;
        check_model("rnd_rst");
        N_rst = 1'b1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
